// File: rtl/mac_iter.sv
`default_nettype none
// ============================================================================
// Module     : mac_iter
// Description: Iterative signed/unsigned multiply and multiply-accumulate/
//              subtract unit with start/ready handshake for the EX stage.
// Revision   : 1.0 - initial release
// ============================================================================
module mac_iter #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic [2*WIDTH-1:0]   hilo_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_ACC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_busy;
    logic               r_ready;
    logic               r_neg;
    logic [1:0]         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [PW-1:0]      r_prod;
    logic [PW-1:0]      r_hilo;
    logic [PW-1:0]      r_result;

    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [PW-1:0]      w_partial;
    logic [PW-1:0]      w_p;
    logic [PW-1:0]      w_acc_res;

    // Magnitudes are held unsigned, so -2^(WIDTH-1) maps to itself exactly.
    assign w_abs1 = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign w_abs2 = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i && !annul_i)
                    w_state_nxt = (w_abs1 == '0 || w_abs2 == '0) ? S_ACC : S_CALC;
            end
            S_CALC: begin
                if (!start_i || annul_i)
                    w_state_nxt = S_IDLE;
                else if (r_cnt == CNT_W'(N - 1))
                    w_state_nxt = S_ACC;
            end
            S_ACC: begin
                w_state_nxt = annul_i ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                if (!start_i || annul_i)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Multiplicand is pre-shifted each cycle, so the digit weight is implicit.
    always_comb begin
        w_partial = '0;
        for (int b = 0; b < BITS_PER_CYCLE; b++) begin
            if (r_mplier[b])
                w_partial = w_partial + (r_mcand << b);
        end
    end

    always_comb begin
        w_p = r_neg ? -r_prod : r_prod;
        case (r_op)
            2'b01:   w_acc_res = r_hilo + w_p;
            2'b10:   w_acc_res = r_hilo - w_p;
            default: w_acc_res = w_p;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_CALC) || (w_state_nxt == S_ACC);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready  <= 1'b0;
            r_neg    <= 1'b0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_hilo   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_state_nxt != S_IDLE) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_abs1};
                        r_mplier <= w_abs2;
                        r_neg    <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        r_op     <= op_i;
                        r_hilo   <= hilo_i;
                        r_prod   <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_CALC: begin
                    if (w_state_nxt != S_IDLE) begin
                        r_prod   <= r_prod + w_partial;
                        r_mcand  <= r_mcand << BITS_PER_CYCLE;
                        r_mplier <= r_mplier >> BITS_PER_CYCLE;
                        r_cnt    <= r_cnt + CNT_W'(1);
                    end
                end
                S_ACC: begin
                    if (w_state_nxt == S_DONE) begin
                        r_result <= w_acc_res;
                        r_ready  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_state_nxt == S_IDLE)
                        r_ready <= 1'b0;
                end
                default: r_ready <= 1'b0;
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign busy_o   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mac_iter.sv
`default_nettype none
// ============================================================================
// Module     : tb_mac_iter
// Description: Self-checking bench for mac_iter, BITS_PER_CYCLE=1 and 4.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_mac_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  start, annul, sgn, ready, busy;
    logic [1:0]  op   [2];
    logic [31:0] a    [2];
    logic [31:0] b    [2];
    logic [63:0] hilo [2];
    logic [63:0] res  [2];

    logic [63:0] exp_res [2];
    logic [1:0]  exp_ready, exp_busy;
    logic        chk_en = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    mac_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start[0]), .annul_i(annul[0]),
        .signed_i(sgn[0]), .op_i(op[0]), .opdata1_i(a[0]), .opdata2_i(b[0]),
        .hilo_i(hilo[0]), .result_o(res[0]), .ready_o(ready[0]), .busy_o(busy[0])
    );

    mac_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(start[1]), .annul_i(annul[1]),
        .signed_i(sgn[1]), .op_i(op[1]), .opdata1_i(a[1]), .opdata2_i(b[1]),
        .hilo_i(hilo[1]), .result_o(res[1]), .ready_o(ready[1]), .busy_o(busy[1])
    );

    function automatic logic [63:0] model(input logic s, input logic [1:0] o,
                                          input logic [31:0] x, input logic [31:0] y,
                                          input logic [63:0] h);
        logic [63:0] p;
        longint      sx, sy;
        if (s) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            p  = sx * sy;
        end else begin
            p = {32'd0, x} * {32'd0, y};
        end
        case (o)
            2'b01:   return h + p;
            2'b10:   return h - p;
            default: return p;
        endcase
    endfunction

    task automatic chk(input string name, input int i, input logic [63:0] act,
                       input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, i, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("ready",  i, 64'(ready[i]), 64'(exp_ready[i]));
                chk("busy",   i, 64'(busy[i]),  64'(exp_busy[i]));
                chk("result", i, res[i], exp_res[i]);
            end
        end
    end

    // Called #1 after an edge; returns #1 after the edge that saw start_i low.
    task automatic run_op(input int i, input logic s, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] h, input int hold,
                          input logic use_lit, input logic [63:0] lit, input string name);
        int          lat;
        logic [63:0] m;
        lat = (x == 0 || y == 0) ? 2 : ((i == 0) ? 32 : 8) + 2;
        m   = model(s, o, x, y, h);
        start[i] = 1'b1; sgn[i] = s; op[i] = o; a[i] = x; b[i] = y; hilo[i] = h;
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                a[i]    = $urandom;
                b[i]    = $urandom;
                hilo[i] = {$urandom, $urandom};
                sgn[i]  = ~s;
                op[i]   = 2'($urandom_range(0, 3));
            end
            exp_busy[i] = (c < lat);
            if (c == lat) begin
                exp_ready[i] = 1'b1;
                exp_res[i]   = m;
                if (use_lit) chk(name, i, res[i], lit);
            end
        end
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
        end
        start[i] = 1'b0;
        @(posedge clk); #1;
        exp_ready[i] = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = '0; annul = '0; sgn = '0;
        exp_ready = '0; exp_busy = '0;
        for (int i = 0; i < 2; i++) begin
            op[i] = '0; a[i] = '0; b[i] = '0; hilo[i] = '0; exp_res[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        run_op(0, 1'b0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 1, 1'b1,
               64'hFFFFFFFE_00000001, "multu_max");
        run_op(0, 1'b1, 2'b00, 32'hFFFFFFFF, 32'h00000002, 64'h0, 0, 1'b1,
               64'hFFFFFFFF_FFFFFFFE, "mult_neg");
        run_op(0, 1'b1, 2'b00, 32'h80000000, 32'h80000000, 64'h0, 2, 1'b1,
               64'h40000000_00000000, "mult_minmin");
        run_op(0, 1'b0, 2'b01, 32'h3, 32'h4, 64'h5, 0, 1'b1,
               64'h00000000_00000011, "maddu");
        run_op(0, 1'b1, 2'b10, 32'h80000000, 32'h7FFFFFFF, 64'h0, 1, 1'b1,
               64'h3FFFFFFF_80000000, "msub");
        run_op(0, 1'b1, 2'b01, 32'h0, 32'h1234, 64'h7, 1, 1'b1,
               64'h7, "zero_madd");

        // Annul during the fifth CALC cycle: result keeps its previous value.
        start[0] = 1'b1; sgn[0] = 1'b0; op[0] = 2'b00; a[0] = 32'd7; b[0] = 32'd9;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            exp_busy[0] = 1'b1;
        end
        annul[0] = 1'b1;
        @(posedge clk); #1;
        exp_busy[0] = 1'b0;
        annul[0] = 1'b0; start[0] = 1'b0;
        @(posedge clk); #1;

        // Reset pulse mid-CALC clears the result.
        start[0] = 1'b1; a[0] = 32'd11; b[0] = 32'd13;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            exp_busy[0] = 1'b1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start[0] = 1'b0;
        exp_busy = '0; exp_ready = '0; exp_res[0] = '0; exp_res[1] = '0;
        repeat (3) begin
            @(posedge clk); #1;
        end

        run_op(1, 1'b1, 2'b00, 32'hFFFFFFFF, 32'h00000002, 64'h0, 2, 1'b1,
               64'hFFFFFFFF_FFFFFFFE, "mult_neg_bpc4");
        run_op(1, 1'b0, 2'b00, 32'h1234, 32'h0, 64'h55, 0, 1'b1,
               64'h0, "zero_bpc4");
        run_op(1, 1'b0, 2'b10, 32'h10, 32'h10, 64'h100, 1, 1'b1,
               64'h0, "msubu_bpc4");
        for (int k = 0; k < 12; k++) begin
            run_op(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   $urandom, $urandom, {$urandom, $urandom},
                   int'($urandom_range(0, 2)), 1'b0, 64'h0, "rand");
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
